// File: rtl/clk_div_pkg.sv
// Shared definitions for the run-time clock divider controller.
//   DefCntW  : default width of the half-period value and counter
//   DefHalf  : default half-period loaded at reset (3 => divide by 6)
//   state_t  : controller state encoding (StIdle, StRun, StPend)
package clk_div_pkg;

    localparam int unsigned DefCntW = 8;
    localparam int unsigned DefHalf = 3;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0; // clk_out parked low, counter held at 0
    localparam state_t StRun  = 2'd1; // counting, ready for a request
    localparam state_t StPend = 2'd2; // request latched, waiting for period end

endpackage

// File: rtl/clk_div_if.sv
// Configuration handshake between the config register block and the divider controller.
//   cfg_valid / cfg_ready : request handshake, accepted when both are high
//   cfg_half              : requested half-period (0 is rejected)
//   cfg_en                : requested enable (0 parks clk_out low)
//   cfg_done              : one-cycle pulse when a pending request has been applied
//   cfg_err               : one-cycle pulse when a request was rejected
// master = requester, slave = controller.
interface clk_div_if #(
    parameter int unsigned CNT_W = clk_div_pkg::DefCntW
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_en;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_half,
        output cfg_en,
        input  cfg_ready,
        input  cfg_done,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_half,
        input  cfg_en,
        output cfg_ready,
        output cfg_done,
        output cfg_err
    );

endinterface

// File: rtl/clk_div_core.sv
// Half-period counter and toggle flop that generate the divided clock.
//   clk, reset  : system clock, synchronous active-high reset
//   run         : count and toggle; when low, counter and clk_out are held at 0
//   clr         : synchronous clear of counter, clk_out and tick (wins over run)
//   load_half   : capture half_in as the new half-period
//   half_in     : half-period value to load (never 0)
//   clk_out     : divided clock, period 2*half, 50% duty
//   tick        : registered pulse in the first cycle clk_out is high
//   at_boundary : current cycle ends a full output period (end of high phase)
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = DefCntW,
    parameter int unsigned DEF_HALF = DefHalf
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clr,
    input  logic             load_half,
    input  logic [CNT_W-1:0] half_in,
    output logic             clk_out,
    output logic             tick,
    output logic             at_boundary
);

    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_q;
    logic             tick_q;
    logic             last;

    // half_q is never 0, so half_q-1 cannot wrap.
    assign last = (cnt_q == (half_q - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            half_q <= CNT_W'(DEF_HALF);
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            if (load_half) begin
                half_q <= half_in;
            end
            if (clr || !run) begin
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (last) begin
                cnt_q  <= '0;
                clk_q  <= ~clk_q;
                tick_q <= ~clk_q; // rising edge of clk_out
            end else begin
                cnt_q  <= cnt_q + CNT_W'(1);
                tick_q <= 1'b0;
            end
        end
    end

    assign clk_out     = clk_q;
    assign tick        = tick_q;
    assign at_boundary = run & clk_q & last;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the clock divider. Owns divide ratio and enable, accepts
// reconfiguration over a valid/ready handshake and applies it only at a full output
// period boundary, so clk_out never shows a runt phase.
//   clk, reset : system clock, synchronous active-high reset
//   cfg        : configuration handshake (slave side)
//   clk_out    : divided clock
//   tick       : one-cycle pulse in the cycle clk_out goes 0->1
//   active     : high while running (RUN or PEND)
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = DefCntW,
    parameter int unsigned DEF_HALF = DefHalf
) (
    input  logic    clk,
    input  logic    reset,
    clk_div_if.slave cfg,
    output logic    clk_out,
    output logic    tick,
    output logic    active
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pend_half_q;
    logic             pend_en_q;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             legal;
    logic             core_run;
    logic             core_clr;
    logic             core_load;
    logic [CNT_W-1:0] core_half;
    logic             at_boundary;

    assign cfg.cfg_ready = (state_q != StPend);
    assign accept        = cfg.cfg_valid & cfg.cfg_ready;
    assign legal         = (cfg.cfg_half != '0);
    assign core_run      = (state_q != StIdle);

    always_comb begin
        state_d   = state_q;
        core_clr  = 1'b0;
        core_load = 1'b0;
        core_half = cfg.cfg_half;
        done_d    = 1'b0;
        // Illegal requests are consumed with no other effect.
        err_d     = accept & ~legal;
        case (state_q)
            StIdle: begin
                if (accept && legal) begin
                    core_clr  = 1'b1;
                    core_load = 1'b1;
                    done_d    = 1'b1;
                    state_d   = cfg.cfg_en ? StRun : StIdle;
                end
            end
            StRun: begin
                // A request on a boundary cycle waits for the next boundary.
                if (accept && legal) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (at_boundary) begin
                    core_clr  = 1'b1;
                    core_load = 1'b1;
                    core_half = pend_half_q;
                    done_d    = 1'b1;
                    state_d   = pend_en_q ? StRun : StIdle;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            pend_half_q <= '0;
            pend_en_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (state_q == StRun && accept && legal) begin
                pend_half_q <= cfg.cfg_half;
                pend_en_q   <= cfg.cfg_en;
            end
        end
    end

    assign cfg.cfg_done = done_q;
    assign cfg.cfg_err  = err_q;
    assign active       = core_run;

    clk_div_core #(
        .CNT_W   (CNT_W),
        .DEF_HALF(DEF_HALF)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .run        (core_run),
        .clr        (core_clr),
        .load_half  (core_load),
        .half_in    (core_half),
        .clk_out    (clk_out),
        .tick       (tick),
        .at_boundary(at_boundary)
    );

endmodule
